// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle CPU control sequencer: fetch/decode/execute/memory/writeback with trap and WFI handling.
// state | meaning: RESET init, FETCH wait imem, DECODE classify, EXEC branch/xret/nop, MEM data access, WB writeback, TRAP vector, WFI sleep
module cpu_ctrl_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_ready,
  input  logic [47:0]      inst_flags,
  input  logic             invalid_instruction,
  input  logic             branch_taken,
  input  logic             dmem_ready,
  input  logic             dmem_err,
  input  logic             irq,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dec_en,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_we,
  output logic             csr_we,
  output logic             pc_we,
  output logic             trap,
  output logic             instret,
  output logic [1:0]       pc_sel,
  output logic [1:0]       trap_cause,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret_cnt
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6,
    S_WFI    = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_ALU, C_BRANCH, C_JUMP, C_LOAD, C_STORE, C_CSR,
    C_XRET, C_WFI, C_ECALL, C_EBREAK, C_ILLEGAL
  } class_t;

  state_t     state_q, state_d;
  class_t     cls_q, dec_class;
  logic [1:0] cause_q, cause_d;
  logic       multi_hot;

  // x & (x-1) is nonzero exactly when more than one flag is set
  assign multi_hot = |(inst_flags & (inst_flags - 48'd1));

  always_comb begin
    dec_class = C_NOP;
    if (invalid_instruction || multi_hot)  dec_class = C_ILLEGAL;
    else if (inst_flags[7])                dec_class = C_ECALL;
    else if (inst_flags[6])                dec_class = C_EBREAK;
    else if (inst_flags[9])                dec_class = C_WFI;
    else if (|inst_flags[24:20])           dec_class = C_LOAD;
    else if (|inst_flags[19:17])           dec_class = C_STORE;
    else if (|inst_flags[47:42])           dec_class = C_BRANCH;
    else if (inst_flags[8] || inst_flags[10]) dec_class = C_XRET;
    else if (|inst_flags[16:11])           dec_class = C_CSR;
    else if (|inst_flags[5:4])             dec_class = C_JUMP;
    else if (|inst_flags)                  dec_class = C_ALU;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RESET;
      cls_q       <= C_NOP;
      cause_q     <= 2'd0;
      instret_cnt <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (state_q == S_DECODE) cls_q <= dec_class;
      if (instret) instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dec_en   = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    reg_we   = 1'b0;
    csr_we   = 1'b0;
    pc_we    = 1'b0;
    trap     = 1'b0;
    instret  = 1'b0;
    pc_sel   = 2'd0;
    unique case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        dec_en = 1'b1;
        case (dec_class)
          C_ILLEGAL:       begin state_d = S_TRAP; cause_d = 2'd0; end
          C_ECALL:         begin state_d = S_TRAP; cause_d = 2'd1; end
          C_EBREAK:        begin state_d = S_TRAP; cause_d = 2'd2; end
          C_WFI:           state_d = S_WFI;
          C_LOAD, C_STORE: state_d = S_MEM;
          default:         state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls_q)
          C_BRANCH: begin
            pc_we   = 1'b1;
            pc_sel  = branch_taken ? 2'd1 : 2'd0;
            instret = 1'b1;
            state_d = S_FETCH;
          end
          C_XRET: begin
            pc_we   = 1'b1;
            pc_sel  = 2'd3;
            instret = 1'b1;
            state_d = S_FETCH;
          end
          C_NOP: begin
            pc_we   = 1'b1;
            instret = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == C_STORE);
        if (dmem_ready) begin
          if (dmem_err) begin
            cause_d = 2'd3;
            state_d = S_TRAP;
          end else if (cls_q == C_STORE) begin
            pc_we   = 1'b1;
            instret = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        csr_we  = (cls_q == C_CSR);
        pc_we   = 1'b1;
        pc_sel  = (cls_q == C_JUMP) ? 2'd1 : 2'd0;
        instret = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        trap    = 1'b1;
        pc_we   = 1'b1;
        pc_sel  = 2'd2;
        state_d = S_FETCH;
      end
      S_WFI: begin
        if (irq) begin
          pc_we   = 1'b1;
          instret = 1'b1;
          state_d = S_FETCH;
        end
      end
    endcase
  end

  assign state      = state_q;
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: stimulus pushes expected retire/trap responses, a monitor checks each pc_we cycle.
module tb_cpu_ctrl_fsm;

  logic        clk, rst, imem_ready, invalid_instruction, branch_taken;
  logic        dmem_ready, dmem_err, irq;
  logic [47:0] inst_flags;
  logic        imem_req, ir_we, dec_en, dmem_req, dmem_we, reg_we, csr_we;
  logic        pc_we, trap, instret;
  logic [1:0]  pc_sel, trap_cause;
  logic [2:0]  state;
  logic [3:0]  instret_cnt;

  cpu_ctrl_fsm #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .imem_ready(imem_ready), .inst_flags(inst_flags),
    .invalid_instruction(invalid_instruction), .branch_taken(branch_taken),
    .dmem_ready(dmem_ready), .dmem_err(dmem_err), .irq(irq),
    .imem_req(imem_req), .ir_we(ir_we), .dec_en(dec_en), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .reg_we(reg_we), .csr_we(csr_we), .pc_we(pc_we),
    .trap(trap), .instret(instret), .pc_sel(pc_sel), .trap_cause(trap_cause),
    .state(state), .instret_cnt(instret_cnt)
  );

  typedef struct packed {
    logic [1:0] sel;
    logic       rw;
    logic       cw;
    logic       tr;
    logic [1:0] cause;
    logic       ir;
    logic [3:0] cnt;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] model_cnt = 4'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Monitor: every pc_we cycle is one architectural response
  always @(negedge clk) begin
    exp_t a, e;
    if (!rst && pc_we) begin
      a.sel = pc_sel; a.rw = reg_we; a.cw = csr_we; a.tr = trap;
      a.cause = trap ? trap_cause : 2'd0; a.ir = instret; a.cnt = instret_cnt;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL retire_unexpected: got %h, no response expected", a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL retire: got sel=%0d rw=%b cw=%b tr=%b cause=%0d ir=%b cnt=%0d, want sel=%0d rw=%b cw=%b tr=%b cause=%0d ir=%b cnt=%0d",
                   a.sel, a.rw, a.cw, a.tr, a.cause, a.ir, a.cnt,
                   e.sel, e.rw, e.cw, e.tr, e.cause, e.ir, e.cnt);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  task automatic run(input logic [47:0] f, input logic inv, input logic tk,
                     input int mdelay, input logic err, input int wdelay, input logic stray,
                     input logic [1:0] sel, input logic rw, input logic cw, input logic tr,
                     input logic [1:0] cause, input logic ir,
                     output int lat, output int reqc, output logic saw_rw,
                     output logic saw_dwe, output int wfic);
    exp_t e;
    bit   done;
    int   mc;
    e.sel = sel; e.rw = rw; e.cw = cw; e.tr = tr;
    e.cause = tr ? cause : 2'd0; e.ir = ir; e.cnt = model_cnt;
    model_cnt = model_cnt + {3'd0, ir};
    exp_q.push_back(e);
    inst_flags = f; invalid_instruction = inv; branch_taken = tk;
    lat = 0; reqc = 0; saw_rw = 1'b0; saw_dwe = 1'b0; wfic = 0; mc = 0; done = 1'b0;
    while (!done && lat < 100) begin
      imem_ready = (state == 3'd1);
      dmem_ready = 1'b0; dmem_err = 1'b0; irq = stray;
      if (state == 3'd4) begin
        mc++;
        if (mc >= mdelay) begin dmem_ready = 1'b1; dmem_err = err; end
      end
      if (state == 3'd7) begin
        wfic++;
        irq = (wfic > wdelay);
      end
      @(negedge clk);
      if (dmem_req) reqc++;
      if (reg_we)   saw_rw = 1'b1;
      if (dmem_we)  saw_dwe = 1'b1;
      done = pc_we;
      @(posedge clk); #1;
      lat++;
    end
    imem_ready = 1'b0; dmem_ready = 1'b0; dmem_err = 1'b0; irq = 1'b0;
    inst_flags = '0; invalid_instruction = 1'b0; branch_taken = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout: instruction never reached pc_we, want retire within 100 cycles");
    end
  endtask

  task automatic reset_pulse(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, "_outs_zero"}, {18'd0, imem_req, ir_we, dec_en, dmem_req, dmem_we, reg_we,
         csr_we, pc_we, trap, instret, pc_sel, trap_cause}, 32'd0);
    chk({tag, "_state"}, {29'd0, state}, 32'd0);
    chk({tag, "_cnt"}, {28'd0, instret_cnt}, 32'd0);
    model_cnt = 4'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk({tag, "_hold_reset"}, {29'd0, state}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_to_fetch"}, {29'd0, state}, 32'd1);
  endtask

  function automatic logic [47:0] bit1(input int i);
    logic [47:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  initial begin
    int lat, reqc, wfic;
    logic srw, sdwe;
    rst = 1'b1; imem_ready = 1'b0; inst_flags = '0; invalid_instruction = 1'b0;
    branch_taken = 1'b0; dmem_ready = 1'b0; dmem_err = 1'b0; irq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_pulse("por");

    // addi (alu): F D E WB
    run(bit1(41), 0, 0, 0, 0, 0, 0, 2'd0, 1, 0, 0, 2'd0, 1, lat, reqc, srw, sdwe, wfic);
    chk("addi_latency", lat, 4);
    chk("addi_cnt", {28'd0, instret_cnt}, 32'd1);
    // lw, dmem_ready in the third MEM cycle
    run(bit1(22), 0, 0, 3, 0, 0, 0, 2'd0, 1, 0, 0, 2'd0, 1, lat, reqc, srw, sdwe, wfic);
    chk("lw_dmem_req_cycles", reqc, 3);
    chk("lw_no_dmem_we", {31'd0, sdwe}, 32'd0);
    // sw
    run(bit1(17), 0, 0, 1, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 1, lat, reqc, srw, sdwe, wfic);
    chk("sw_dmem_we", {31'd0, sdwe}, 32'd1);
    chk("sw_no_reg_we", {31'd0, srw}, 32'd0);
    // beq taken, bne not taken
    run(bit1(42), 0, 1, 0, 0, 0, 0, 2'd1, 0, 0, 0, 2'd0, 1, lat, reqc, srw, sdwe, wfic);
    chk("beq_latency", lat, 3);
    run(bit1(47), 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 1, lat, reqc, srw, sdwe, wfic);
    chk("bne_no_reg_we", {31'd0, srw}, 32'd0);
    // traps: invalid, ecall, ebreak, two flags, data fault
    run(48'd0, 1, 0, 0, 0, 0, 0, 2'd2, 0, 0, 1, 2'd0, 0, lat, reqc, srw, sdwe, wfic);
    chk("illegal_latency", lat, 3);
    chk("illegal_cnt_unchanged", {28'd0, instret_cnt}, 32'd5);
    run(bit1(7), 0, 0, 0, 0, 0, 0, 2'd2, 0, 0, 1, 2'd1, 0, lat, reqc, srw, sdwe, wfic);
    run(bit1(6), 0, 0, 0, 0, 0, 0, 2'd2, 0, 0, 1, 2'd2, 0, lat, reqc, srw, sdwe, wfic);
    run(bit1(41) | bit1(4), 0, 0, 0, 0, 0, 0, 2'd2, 0, 0, 1, 2'd0, 0, lat, reqc, srw, sdwe, wfic);
    run(bit1(22), 0, 0, 2, 1, 0, 0, 2'd2, 0, 0, 1, 2'd3, 0, lat, reqc, srw, sdwe, wfic);
    chk("lw_err_no_reg_we", {31'd0, srw}, 32'd0);
    chk("lw_err_cnt_unchanged", {28'd0, instret_cnt}, 32'd5);
    // wfi: five idle WFI cycles, wake on the sixth
    run(bit1(9), 0, 0, 0, 0, 5, 0, 2'd0, 0, 0, 0, 2'd0, 1, lat, reqc, srw, sdwe, wfic);
    chk("wfi_cycles", wfic, 6);
    chk("wfi_latency", lat, 8);
    // jal, csr, mret, nop, addi with stray irq
    run(bit1(4), 0, 0, 0, 0, 0, 0, 2'd1, 1, 0, 0, 2'd0, 1, lat, reqc, srw, sdwe, wfic);
    run(bit1(16), 0, 0, 0, 0, 0, 0, 2'd0, 1, 1, 0, 2'd0, 1, lat, reqc, srw, sdwe, wfic);
    run(bit1(8), 0, 0, 0, 0, 0, 0, 2'd3, 0, 0, 0, 2'd0, 1, lat, reqc, srw, sdwe, wfic);
    run(48'd0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 1, lat, reqc, srw, sdwe, wfic);
    chk("nop_latency", lat, 3);
    run(bit1(41), 0, 0, 0, 0, 0, 1, 2'd0, 1, 0, 0, 2'd0, 1, lat, reqc, srw, sdwe, wfic);
    chk("stray_irq_latency", lat, 4);
    chk("cnt_after_mix", {28'd0, instret_cnt}, 32'd11);

    // reset mid-MEM
    inst_flags = bit1(22);
    imem_ready = 1'b1;
    @(posedge clk); #1;
    imem_ready = 1'b0;
    @(posedge clk); #1;
    chk("mem_entered", {31'd0, dmem_req}, 32'd1);
    #2;
    inst_flags = '0;
    reset_pulse("rst_mem");
    // reset mid-FETCH
    chk("fetch_imem_req", {31'd0, imem_req}, 32'd1);
    #2;
    reset_pulse("rst_fetch");

    // counter wrap on the 4-bit instance
    repeat (15)
      run(48'd0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 1, lat, reqc, srw, sdwe, wfic);
    chk("cnt_all_ones", {28'd0, instret_cnt}, 32'd15);
    run(bit1(41), 0, 0, 0, 0, 0, 0, 2'd0, 1, 0, 0, 2'd0, 1, lat, reqc, srw, sdwe, wfic);
    chk("cnt_wrap", {28'd0, instret_cnt}, 32'd0);

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
